// File: rtl/pat_det_rr_sched.sv
// Round-robin scheduler sharing one BCBBCB pattern detector among NREQ serial
// requesters, one frame at a time, returning a hit-count record per frame.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | wait for any requester valid; latch round-robin winner
// S_CLR    | one-cycle synchronous clear of the shared detector
// S_STREAM | forward granted requester's bits until the beat marked last
// S_DRAIN  | one cycle to catch the registered hit of the final bit
// S_RESULT | hold the result record until the consumer accepts it
module pat_det_rr_sched #(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [NREQ-1:0]  req_valid_i,
    input  logic [NREQ-1:0]  req_d_i,
    input  logic [NREQ-1:0]  req_last_i,
    output logic [NREQ-1:0]  req_ready_o,
    output logic             det_rst_o,
    output logic             det_valid_o,
    output logic             det_d_o,
    input  logic             det_hit_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [ID_W-1:0]  res_id_o,
    output logic [CNT_W-1:0] res_count_o,
    output logic             res_ovf_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_STREAM,
        S_DRAIN,
        S_RESULT
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic             found_hi, found_any;
    logic [ID_W-1:0]  pick_hi, pick_any, pick;
    logic             det_clr;
    logic             hit_window;

    // Descending scan leaves the lowest matching index; the "hi" search covers
    // indices at or above the pointer, the "any" search provides the wrap.
    always_comb begin
        found_hi  = 1'b0;
        pick_hi   = '0;
        found_any = 1'b0;
        pick_any  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                found_any = 1'b1;
                pick_any  = ID_W'(i);
                if (ID_W'(i) >= ptr_q) begin
                    found_hi = 1'b1;
                    pick_hi  = ID_W'(i);
                end
            end
        end
    end

    assign pick = found_hi ? pick_hi : pick_any;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        req_ready_o = '0;
        det_clr     = 1'b0;
        det_valid_o = 1'b0;
        det_d_o     = 1'b0;
        res_valid_o = 1'b0;
        res_id_o    = '0;
        res_count_o = '0;
        res_ovf_o   = 1'b0;
        hit_window  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found_any) begin
                    grant_d = pick;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                det_clr = 1'b1;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                req_ready_o[grant_q] = 1'b1;
                det_valid_o          = req_valid_i[grant_q];
                det_d_o              = req_d_i[grant_q];
                hit_window           = 1'b1;
                if (req_valid_i[grant_q] && req_last_i[grant_q]) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                hit_window = 1'b1;
                state_d    = S_RESULT;
            end
            S_RESULT: begin
                res_valid_o = 1'b1;
                res_id_o    = grant_q;
                res_count_o = count_q;
                res_ovf_o   = ovf_q;
                if (res_ready_i) begin
                    ptr_d   = (grant_q == ID_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A hit while already saturated only marks overflow.
        if (hit_window && det_hit_i) begin
            if (count_q == '1) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Detector is held clear for as long as the scheduler is in reset.
    assign det_rst_o = det_clr | ~rst_n_i;

endmodule

// File: tb/tb_pat_det_rr_sched.sv
// Directed bench for pat_det_rr_sched: frame table plus hand-written multi-cycle
// sequences, with a behavioural non-overlapping BCBBCB detector per instance.
module tb_pat_det_rr_sched;

    localparam int NREQ   = 4;
    localparam int ID_W   = 2;
    localparam int CNT_W  = 8;
    localparam int CNT2_W = 2;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic             rst_n_i;
    logic [NREQ-1:0]  req_valid_i, req_d_i, req_last_i, req_ready_o;
    logic             det_rst_o, det_valid_o, det_d_o, det_hit_i;
    logic             res_valid_o, res_ready_i, res_ovf_o;
    logic [ID_W-1:0]  res_id_o;
    logic [CNT_W-1:0] res_count_o;

    logic [NREQ-1:0]   req_valid_2, req_d_2, req_last_2, req_ready_2;
    logic              det_rst_2, det_valid_2, det_d_2, det_hit_2;
    logic              res_valid_2, res_ready_2, res_ovf_2;
    logic [ID_W-1:0]   res_id_2;
    logic [CNT2_W-1:0] res_count_2;

    pat_det_rr_sched #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_d_i(req_d_i), .req_last_i(req_last_i),
        .req_ready_o(req_ready_o),
        .det_rst_o(det_rst_o), .det_valid_o(det_valid_o), .det_d_o(det_d_o),
        .det_hit_i(det_hit_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_id_o(res_id_o),
        .res_count_o(res_count_o), .res_ovf_o(res_ovf_o)
    );

    pat_det_rr_sched #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT2_W)) dut2 (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_2), .req_d_i(req_d_2), .req_last_i(req_last_2),
        .req_ready_o(req_ready_2),
        .det_rst_o(det_rst_2), .det_valid_o(det_valid_2), .det_d_o(det_d_2),
        .det_hit_i(det_hit_2),
        .res_valid_o(res_valid_2), .res_ready_i(res_ready_2), .res_id_o(res_id_2),
        .res_count_o(res_count_2), .res_ovf_o(res_ovf_2)
    );

    // Non-overlapping BCBBCB detector: registered hit one cycle after the bit.
    logic [5:0] sr1, sr2;
    int         n1, n2;

    always @(posedge clk_i) begin
        if (det_rst_o) begin
            sr1 <= '0; n1 <= 0; det_hit_i <= 1'b0;
        end else if (det_valid_o) begin
            if (n1 >= 5 && {sr1[4:0], det_d_o} == 6'b101101) begin
                det_hit_i <= 1'b1; n1 <= 0; sr1 <= '0;
            end else begin
                det_hit_i <= 1'b0; sr1 <= {sr1[4:0], det_d_o}; n1 <= (n1 < 5) ? n1 + 1 : 5;
            end
        end else begin
            det_hit_i <= 1'b0;
        end
    end

    always @(posedge clk_i) begin
        if (det_rst_2) begin
            sr2 <= '0; n2 <= 0; det_hit_2 <= 1'b0;
        end else if (det_valid_2) begin
            if (n2 >= 5 && {sr2[4:0], det_d_2} == 6'b101101) begin
                det_hit_2 <= 1'b1; n2 <= 0; sr2 <= '0;
            end else begin
                det_hit_2 <= 1'b0; sr2 <= {sr2[4:0], det_d_2}; n2 <= (n2 < 5) ? n2 + 1 : 5;
            end
        end else begin
            det_hit_2 <= 1'b0;
        end
    end

    // Per-requester bit queues of {last, d}, drained by accepted beats.
    logic [1:0]      q [NREQ][$];
    logic [NREQ-1:0] stall = '0;
    logic [NREQ-1:0] taken;

    initial begin
        req_valid_i = '0; req_d_i = '0; req_last_i = '0; taken = '0;
        forever begin
            @(negedge clk_i);
            taken = req_valid_i & req_ready_o;
            @(posedge clk_i);
            #1;
            for (int c = 0; c < NREQ; c++) begin
                if (taken[c] && q[c].size() > 0) void'(q[c].pop_front());
                if (q[c].size() > 0 && !stall[c]) begin
                    req_valid_i[c] = 1'b1;
                    req_d_i[c]     = q[c][0][0];
                    req_last_i[c]  = q[c][0][1];
                end else begin
                    req_valid_i[c] = 1'b0;
                    req_d_i[c]     = 1'b0;
                    req_last_i[c]  = 1'b0;
                end
            end
        end
    end

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } res_t;

    res_t            res_log[$];
    int              grant_log[$];
    logic [NREQ-1:0] prev_ready = '0;
    int              viol = 0;
    int              cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (res_valid_o && res_ready_i) res_log.push_back({res_id_o, res_count_o, res_ovf_o});
        if (req_ready_o != '0 && prev_ready == '0) begin
            for (int c = 0; c < NREQ; c++) if (req_ready_o[c]) grant_log.push_back(c);
        end
        prev_ready <= req_ready_o;
        if (rst_n_i) begin
            viol <= viol + int'(!$onehot0(req_ready_o))
                         + int'(det_rst_o && req_ready_o != '0)
                         + int'(res_valid_o && req_ready_o != '0)
                         + int'(det_valid_o && (req_ready_o & req_valid_i) == '0);
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic load(input int ch, input int n, input logic [31:0] bits);
        for (int i = n - 1; i >= 0; i--) q[ch].push_back({logic'(i == 0), bits[i]});
    endtask

    task automatic wait_results(input int want, input int lim, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < lim; k++) begin
            @(posedge clk_i);
            #2;
            if (res_log.size() >= want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        int          ch;
        int          n;
        logic [31:0] bits;
        int          exp_cnt;
        logic        exp_ovf;
    } frame_vec_t;

    frame_vec_t tbl[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got hang, want finish");
        $fatal(1);
    end

    initial begin
        bit          ok;
        int          base, c0, lat0, lat1, beats, dv, idx;
        res_t        r;
        logic [29:0] pat;
        logic        stable;
        logic [ID_W-1:0]   h_id;
        logic [CNT2_W-1:0] h_cnt;
        logic              h_ovf;

        tbl[0] = '{0, 12, 32'b101101101101, 2, 1'b0};
        tbl[1] = '{0, 6,  32'b000111,       0, 1'b0};
        tbl[2] = '{1, 1,  32'b1,            0, 1'b0};
        tbl[3] = '{1, 7,  32'b1011010,      1, 1'b0};
        tbl[4] = '{2, 6,  32'b101101,       1, 1'b0};
        tbl[5] = '{3, 8,  32'b10110110,     1, 1'b0};

        rst_n_i = 1'b0; res_ready_i = 1'b1;
        req_valid_2 = '0; req_d_2 = '0; req_last_2 = '0; res_ready_2 = 1'b0;
        #12;
        check("reset_outs", 32'({req_ready_o, det_valid_o, det_d_o, res_valid_o,
                                 res_id_o, res_count_o, res_ovf_o}), 32'd0);
        check("reset_det_rst", 32'(det_rst_o), 32'd1);
        @(negedge clk_i); #2 rst_n_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #2;

        // First frame: clear pulse precedes the first forwarded bit by one cycle.
        load(0, 6, 32'b101101);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (det_rst_o) begin ok = 1'b1; break; end
        end
        check("clr_seen", 32'(ok), 32'd1);
        check("clr_quiet", 32'({req_ready_o, det_valid_o}), 32'd0);
        @(negedge clk_i);
        check("first_beat", 32'({det_rst_o, det_valid_o, req_ready_o}), 32'b010001);
        wait_results(1, 50, ok);
        check("f1_timeout", 32'(ok), 32'd1);
        if (ok) begin
            r = res_log[0];
            check("f1_id", 32'(r.id), 32'd0);
            check("f1_cnt", 32'(r.cnt), 32'd1);
            check("f1_ovf", 32'(r.ovf), 32'd0);
        end
        repeat (10) @(posedge clk_i);
        #2;
        check("f1_single_result", 32'(res_log.size()), 32'd1);

        for (int v = 0; v < 6; v++) begin
            base = res_log.size();
            load(tbl[v].ch, tbl[v].n, tbl[v].bits);
            wait_results(base + 1, 100, ok);
            check($sformatf("tbl%0d_timeout", v), 32'(ok), 32'd1);
            if (ok) begin
                r = res_log[base];
                check($sformatf("tbl%0d_id", v), 32'(r.id), 32'(tbl[v].ch));
                check($sformatf("tbl%0d_cnt", v), 32'(r.cnt), 32'(tbl[v].exp_cnt));
                check($sformatf("tbl%0d_ovf", v), 32'(r.ovf), 32'(tbl[v].exp_ovf));
            end
        end

        // All four requesters busy with two frames each; pointer sits at 0.
        grant_log.delete();
        base = res_log.size();
        for (int c = 0; c < NREQ; c++) begin
            load(c, 6, 32'b101101);
            load(c, 6, 32'b101101);
        end
        wait_results(base + 8, 400, ok);
        check("rr_timeout", 32'(ok), 32'd1);
        check("rr_grants", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            check($sformatf("rr_grant%0d", i), 32'(grant_log[i]), 32'(i % 4));
        for (int i = 0; i < 8 && base + i < res_log.size(); i++) begin
            r = res_log[base + i];
            check($sformatf("rr_id%0d", i), 32'(r.id), 32'(i % 4));
            check($sformatf("rr_cnt%0d", i), 32'(r.cnt), 32'd1);
        end

        // Ch2 unstalled reference: 6 beats + 4 overhead + 1 observation cycle.
        base = res_log.size();
        c0 = cyc;
        load(2, 6, 32'b101101);
        wait_results(base + 1, 100, ok);
        lat0 = cyc - c0;
        check("nostall_lat", 32'(lat0), 32'd11);
        if (ok) check("nostall_cnt", 32'(res_log[base].cnt), 32'd1);

        base = res_log.size();
        c0 = cyc;
        load(2, 6, 32'b101101);
        beats = 0;
        for (int k = 0; k < 50 && beats < 3; k++) begin
            @(negedge clk_i);
            if (req_valid_i[2] && req_ready_o[2]) beats++;
        end
        stall[2] = 1'b1;
        dv = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (det_valid_o) dv++;
        end
        stall[2] = 1'b0;
        wait_results(base + 1, 100, ok);
        lat1 = cyc - c0;
        check("stall_no_beats", 32'(dv), 32'd0);
        check("stall_lat", 32'(lat1), 32'd16);
        if (ok) check("stall_cnt", 32'(res_log[base].cnt), 32'd1);

        // Narrow counter instance: five detections saturate at 3 with overflow.
        pat = {5{6'b101101}};
        idx = 0;
        @(posedge clk_i); #1;
        req_valid_2[0] = 1'b1; req_d_2[0] = pat[29]; req_last_2[0] = 1'b0;
        for (int k = 0; k < 200 && idx < 30; k++) begin
            @(negedge clk_i);
            if (req_ready_2[0] && req_valid_2[0]) idx++;
            @(posedge clk_i); #1;
            if (idx < 30) begin
                req_d_2[0]    = pat[29 - idx];
                req_last_2[0] = (idx == 29);
            end else begin
                req_valid_2[0] = 1'b0; req_d_2[0] = 1'b0; req_last_2[0] = 1'b0;
            end
        end
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_i);
            if (res_valid_2) begin ok = 1'b1; break; end
        end
        check("sat_timeout", 32'(ok), 32'd1);
        check("sat_id", 32'(res_id_2), 32'd0);
        check("sat_cnt", 32'(res_count_2), 32'd3);
        check("sat_ovf", 32'(res_ovf_2), 32'd1);
        h_id = res_id_2; h_cnt = res_count_2; h_ovf = res_ovf_2;
        req_valid_2[1] = 1'b1; req_last_2[1] = 1'b1;
        stable = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            if (!(res_valid_2 && res_id_2 == h_id && res_count_2 == h_cnt && res_ovf_2 == h_ovf
                  && req_ready_2 == '0 && !det_rst_2)) stable = 1'b0;
        end
        check("sat_hold_stable", 32'(stable), 32'd1);
        res_ready_2 = 1'b1;
        @(negedge clk_i);
        check("sat_released", 32'(res_valid_2), 32'd0);
        @(negedge clk_i);
        check("sat_next_grant_clr", 32'(det_rst_2), 32'd1);
        req_valid_2 = '0; req_last_2 = '0;

        // Async reset mid-frame on ch1 aborts it and returns the pointer to 0.
        base = res_log.size();
        load(1, 12, 32'b101101101101);
        beats = 0;
        for (int k = 0; k < 50 && beats < 4; k++) begin
            @(negedge clk_i);
            if (req_valid_i[1] && req_ready_o[1]) beats++;
        end
        #2 rst_n_i = 1'b0;
        #1;
        check("arst_outs", 32'({req_ready_o, det_valid_o, det_d_o, res_valid_o,
                                res_id_o, res_count_o, res_ovf_o}), 32'd0);
        check("arst_det_rst", 32'(det_rst_o), 32'd1);
        @(posedge clk_i); #3;
        q[1].delete();
        repeat (2) @(negedge clk_i);
        load(1, 6, 32'b101101);
        load(3, 6, 32'b101101);
        @(negedge clk_i);
        #2 rst_n_i = 1'b1;
        check("arst_no_result", 32'(res_log.size()), 32'(base));
        wait_results(base + 2, 100, ok);
        check("arst_timeout", 32'(ok), 32'd1);
        if (ok) begin
            check("arst_first_id", 32'(res_log[base].id), 32'd1);
            check("arst_first_cnt", 32'(res_log[base].cnt), 32'd1);
            check("arst_second_id", 32'(res_log[base + 1].id), 32'd3);
        end

        check("protocol_viol", 32'(viol), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
